uart_line_rx: RTL and testbench

Synthesizable, parametrised UART receiver with a line-assembly buffer. It oversamples the serial input, checks configurable data-width/parity/stop framing, and emits each byte. It packs bytes into a line that is presented when the terminator byte arrives. It sits between the board RX pin and the command parser, and replaces the bench-only receive path with an RTL block that adds parity, error reporting and a flow-controlled line handshake.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_core.sv | 131 +++++++++++++
 rtl/uart_line_rx.sv | 94 +++++++++
 tb/tb_uart_line_rx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings and defaults for the UART line receiver.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int         DEF_CLK_HZ     = 100_000_000;
    localparam int         DEF_BAUD       = 115200;
    localparam int         DEF_DATA_BITS  = 8;
    localparam int         DEF_STOP_BITS  = 1;
    localparam int         DEF_LINE_BYTES = 5;
    localparam logic [7:0] TERM_CR        = 8'h0D;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: synchronizer, bit timer, framing FSM and error strobes.
module uart_rx_core import uart_pkg::*; #(
    parameter int CLK_HZ    = DEF_CLK_HZ,
    parameter int BAUD      = DEF_BAUD,
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = DEF_STOP_BITS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic       take_o,
    output logic [7:0] take_data_o,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       parity_err_o,
    output logic       frame_err_o
);
    localparam int             CPB  = CLK_HZ / BAUD;
    localparam int             TW   = $clog2(CPB);
    localparam logic [TW-1:0]  FULL = TW'(CPB - 1);
    localparam logic [TW-1:0]  HALF = TW'(CPB / 2 - 1);
    localparam logic [3:0]     LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic           LAST_STOP = 1'(STOP_BITS - 1);

    rx_state_e                state_q;
    logic [1:0]               sync_q;
    logic                     rx_prev_q;
    logic [TW-1:0]            tmr_q;
    logic [3:0]               bit_q;
    logic                     stop_q;
    logic [DATA_BITS-1:0]     shreg_q;
    logic                     par_bad_q;
    logic                     stop_bad_q;
    logic                     byte_valid_q, parity_err_q, frame_err_q;
    logic [7:0]               byte_q;

    logic rx_s, tick, stop_bad_now, par_exp, last_stop;
    logic [7:0] byte_next;

    assign rx_s         = sync_q[1];
    assign tick         = (tmr_q == '0);
    assign stop_bad_now = stop_bad_q | ~rx_s;
    assign par_exp      = (PARITY == PAR_ODD) ? ~^shreg_q : ^shreg_q;
    assign last_stop    = (state_q == ST_STOP) && tick && (stop_q == LAST_STOP);

    always_comb begin
        byte_next = '0;
        byte_next[DATA_BITS-1:0] = shreg_q;
    end

    // Line accumulator updates on the same edge that raises byte_valid_o.
    assign take_o      = last_stop && !stop_bad_now && !par_bad_q;
    assign take_data_o = byte_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sync_q       <= 2'b11;
            rx_prev_q    <= 1'b1;
            tmr_q        <= '0;
            bit_q        <= '0;
            stop_q       <= 1'b0;
            shreg_q      <= '0;
            par_bad_q    <= 1'b0;
            stop_bad_q   <= 1'b0;
            byte_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            byte_q       <= '0;
        end else begin
            sync_q       <= {sync_q[0], rx_i};
            rx_prev_q    <= rx_s;
            byte_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (state_q != ST_IDLE && state_q != ST_WAIT_IDLE && !tick)
                tmr_q <= tmr_q - 1'b1;
            case (state_q)
                ST_IDLE: if (rx_prev_q && !rx_s) begin
                    state_q <= ST_START;
                    tmr_q   <= HALF;
                end
                ST_START: if (tick) begin
                    tmr_q <= FULL;
                    bit_q <= '0;
                    state_q <= rx_s ? ST_IDLE : ST_DATA;
                end
                ST_DATA: if (tick) begin
                    shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
                    tmr_q   <= FULL;
                    bit_q   <= bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
                        state_q    <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                        stop_q     <= 1'b0;
                        par_bad_q  <= 1'b0;
                        stop_bad_q <= 1'b0;
                    end
                end
                ST_PAR: if (tick) begin
                    par_bad_q <= (rx_s != par_exp);
                    tmr_q     <= FULL;
                    state_q   <= ST_STOP;
                end
                ST_STOP: if (tick) begin
                    if (stop_q == LAST_STOP) begin
                        parity_err_q <= par_bad_q;
                        frame_err_q  <= stop_bad_now;
                        if (!par_bad_q && !stop_bad_now) begin
                            byte_valid_q <= 1'b1;
                            byte_q       <= byte_next;
                        end
                        state_q <= stop_bad_now ? ST_WAIT_IDLE : ST_IDLE;
                    end else begin
                        stop_bad_q <= stop_bad_now;
                        stop_q     <= 1'b1;
                        tmr_q      <= FULL;
                    end
                end
                ST_WAIT_IDLE: if (rx_s) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign byte_valid_o = byte_valid_q;
    assign byte_data_o  = byte_q;
    assign parity_err_o = parity_err_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/uart_line_rx.sv
// UART receiver with a line-assembly buffer presented via a valid/ready handshake.
module uart_line_rx import uart_pkg::*; #(
    parameter int         CLK_HZ     = DEF_CLK_HZ,
    parameter int         BAUD       = DEF_BAUD,
    parameter int         DATA_BITS  = DEF_DATA_BITS,
    parameter int         PARITY     = PAR_NONE,
    parameter int         STOP_BITS  = DEF_STOP_BITS,
    parameter int         LINE_BYTES = DEF_LINE_BYTES,
    parameter logic [7:0] TERM       = TERM_CR
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              rx,
    output logic                              byte_valid,
    output logic [7:0]                        byte_data,
    output logic                              line_valid,
    input  logic                              line_ready,
    output logic [8*LINE_BYTES-1:0]           line_data,
    output logic [$clog2(LINE_BYTES+1)-1:0]   line_len,
    output logic                              line_trunc,
    output logic                              parity_err,
    output logic                              frame_err,
    output logic                              overrun
);
    localparam int AW = 8 * LINE_BYTES;
    localparam int LW = $clog2(LINE_BYTES + 1);

    logic          take;
    logic [7:0]    take_data;

    uart_rx_core #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DATA_BITS),
        .PARITY(PARITY), .STOP_BITS(STOP_BITS)
    ) u_core (
        .clk(clk), .rst_n(rst_n), .rx_i(rx),
        .take_o(take), .take_data_o(take_data),
        .byte_valid_o(byte_valid), .byte_data_o(byte_data),
        .parity_err_o(parity_err), .frame_err_o(frame_err)
    );

    logic [AW-1:0] acc_q, acc_d, line_data_q;
    logic [LW-1:0] cnt_q, cnt_d, line_len_q;
    logic          trunc_q, trunc_d, line_trunc_q, line_valid_q, overrun_q;
    logic          full, accept;

    assign full    = (cnt_q == LW'(LINE_BYTES));
    assign acc_d   = (acc_q << 8) | AW'(take_data);
    assign cnt_d   = full ? cnt_q : cnt_q + 1'b1;
    assign trunc_d = trunc_q | full;
    assign accept  = line_valid_q & line_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            trunc_q      <= 1'b0;
            line_data_q  <= '0;
            line_len_q   <= '0;
            line_trunc_q <= 1'b0;
            line_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (accept) line_valid_q <= 1'b0;
            if (take) begin
                if (take_data == TERM) begin
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    trunc_q <= 1'b0;
                    // A same-cycle handshake frees the slot for the new line.
                    if (!line_valid_q || accept) begin
                        line_valid_q <= 1'b1;
                        line_data_q  <= acc_d;
                        line_len_q   <= cnt_d;
                        line_trunc_q <= trunc_d;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                end else begin
                    acc_q   <= acc_d;
                    cnt_q   <= cnt_d;
                    trunc_q <= trunc_d;
                end
            end
        end
    end

    assign line_valid = line_valid_q;
    assign line_data  = line_data_q;
    assign line_len   = line_len_q;
    assign line_trunc = line_trunc_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_line_rx.sv
// Directed bench for uart_line_rx at 16 clocks/bit, even parity, 5-byte line.
module tb_uart_line_rx;
    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        line_ready = 1'b1;
    logic        byte_valid, line_valid, line_trunc, parity_err, frame_err, overrun;
    logic [7:0]  byte_data;
    logic [39:0] line_data;
    logic [2:0]  line_len;

    int errors = 0;
    int checks = 0;

    // monitor state
    int          n_bv = 0, n_pe = 0, n_fe = 0, n_ov = 0, n_hs = 0;
    logic [7:0]  bq[$];
    logic        s_lv = 1'b0, s_lt = 1'b0;
    logic [39:0] s_ld = '0;
    logic [2:0]  s_ll = '0;

    uart_line_rx #(
        .CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
        .LINE_BYTES(5), .TERM(8'h0D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .line_valid(line_valid), .line_ready(line_ready),
        .line_data(line_data), .line_len(line_len), .line_trunc(line_trunc),
        .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (byte_valid) begin
            n_bv++;
            bq.push_back(byte_data);
            s_lv = line_valid; s_ld = line_data; s_ll = line_len; s_lt = line_trunc;
        end
        if (parity_err) n_pe++;
        if (frame_err)  n_fe++;
        if (overrun)    n_ov++;
        if (line_valid && line_ready) n_hs++;
    end

    task automatic hold_bits(input logic v, input int clocks);
        rx = v;
        repeat (clocks) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        hold_bits(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold_bits(d[i], CPB);
        hold_bits((^d) ^ bad_par, CPB);
        hold_bits(~bad_stop, CPB);
    endtask

    task automatic send_ok(input logic [7:0] d);
        send_frame(d, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({byte_valid, line_valid, line_trunc, parity_err, frame_err, overrun} !== 6'b0) begin
            errors++; $display("FAIL reset_strobes: got %b want 000000",
                {byte_valid, line_valid, line_trunc, parity_err, frame_err, overrun});
        end
        checks++;
        if (line_data !== 40'h0 || line_len !== 3'd0 || byte_data !== 8'h00) begin
            errors++; $display("FAIL reset_data: got ld=%h ll=%0d bd=%h want 0", line_data, line_len, byte_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        hold_bits(1'b1, 2 * CPB);
    endtask

    task automatic test_hi_line;
        int b0 = n_bv;
        int q0 = bq.size();
        send_ok(8'h48); send_ok(8'h49); send_ok(8'h0D);
        hold_bits(1'b1, CPB);
        checks++;
        if (n_bv - b0 !== 3) begin errors++; $display("FAIL hi_count: got %0d want 3", n_bv - b0); end
        checks++;
        if (bq.size() < q0 + 3 || bq[q0] !== 8'h48 || bq[q0+1] !== 8'h49 || bq[q0+2] !== 8'h0D) begin
            errors++; $display("FAIL hi_bytes: wrong byte sequence");
        end
        checks++;
        if (s_lv !== 1'b1) begin errors++; $display("FAIL hi_lv: got %b want 1", s_lv); end
        checks++;
        if (s_ll !== 3'd3) begin errors++; $display("FAIL hi_len: got %0d want 3", s_ll); end
        checks++;
        if (s_ld !== 40'h48490D) begin errors++; $display("FAIL hi_data: got %h want 48490d", s_ld); end
        checks++;
        if (s_lt !== 1'b0) begin errors++; $display("FAIL hi_trunc: got %b want 0", s_lt); end
        checks++;
        if (line_valid !== 1'b0) begin errors++; $display("FAIL hi_consumed: got lv=%b want 0", line_valid); end
    endtask

    task automatic test_parity;
        int b0 = n_bv;
        int p0 = n_pe;
        send_frame(8'h41, 1'b1, 1'b0);
        hold_bits(1'b1, CPB);
        checks++;
        if (n_pe - p0 !== 1) begin errors++; $display("FAIL par_err: got %0d want 1", n_pe - p0); end
        checks++;
        if (n_bv - b0 !== 0) begin errors++; $display("FAIL par_drop: got %0d bytes want 0", n_bv - b0); end
        send_ok(8'h0D);
        hold_bits(1'b1, CPB);
        checks++;
        if (s_ll !== 3'd1 || s_ld !== 40'h0D) begin
            errors++; $display("FAIL par_line: got len=%0d data=%h want 1/0d", s_ll, s_ld);
        end
    endtask

    task automatic test_truncate;
        logic [7:0] s [8];
        s = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h0D};
        for (int i = 0; i < 8; i++) send_ok(s[i]);   // back-to-back, no idle gap
        hold_bits(1'b1, CPB);
        checks++;
        if (s_ll !== 3'd5) begin errors++; $display("FAIL trunc_len: got %0d want 5", s_ll); end
        checks++;
        if (s_ld !== 40'h444546470D) begin errors++; $display("FAIL trunc_data: got %h want 444546470d", s_ld); end
        checks++;
        if (s_lt !== 1'b1) begin errors++; $display("FAIL trunc_flag: got %b want 1", s_lt); end
    endtask

    task automatic test_frame_err;
        int b0 = n_bv;
        int f0 = n_fe;
        int p0 = n_pe;
        send_frame(8'h55, 1'b0, 1'b1);
        hold_bits(1'b0, 3 * CPB);
        checks++;
        if (n_fe - f0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", n_fe - f0); end
        checks++;
        if (n_bv - b0 !== 0 || n_pe - p0 !== 0) begin
            errors++; $display("FAIL ferr_quiet: got bytes=%0d perr=%0d want 0/0", n_bv - b0, n_pe - p0);
        end
        hold_bits(1'b1, CPB);
        send_ok(8'h0D);
        hold_bits(1'b1, CPB);
        checks++;
        if (n_bv - b0 !== 1 || s_ll !== 3'd1) begin
            errors++; $display("FAIL ferr_recover: got bytes=%0d len=%0d want 1/1", n_bv - b0, s_ll);
        end
    endtask

    task automatic test_overrun;
        int o0 = n_ov;
        int h0;
        line_ready = 1'b0;
        send_ok(8'h41); send_ok(8'h0D);
        hold_bits(1'b1, CPB);
        checks++;
        if (line_valid !== 1'b1 || line_data !== 40'h410D || line_len !== 3'd2) begin
            errors++; $display("FAIL ovr_first: got lv=%b data=%h len=%0d want 1/410d/2", line_valid, line_data, line_len);
        end
        send_ok(8'h42); send_ok(8'h0D);
        hold_bits(1'b1, CPB);
        checks++;
        if (n_ov - o0 !== 1) begin errors++; $display("FAIL ovr_count: got %0d want 1", n_ov - o0); end
        checks++;
        if (line_data !== 40'h410D || line_len !== 3'd2) begin
            errors++; $display("FAIL ovr_held: got data=%h len=%0d want 410d/2", line_data, line_len);
        end
        h0 = n_hs;
        line_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (n_hs - h0 !== 1) begin errors++; $display("FAIL ovr_handshake: got %0d want 1", n_hs - h0); end
        checks++;
        if (line_valid !== 1'b0) begin errors++; $display("FAIL ovr_release: got lv=%b want 0", line_valid); end
    endtask

    task automatic test_glitch_reset;
        int b0 = n_bv;
        int e0 = n_pe + n_fe + n_ov;
        hold_bits(1'b0, 4);
        hold_bits(1'b1, 3 * CPB);
        checks++;
        if (n_bv - b0 !== 0 || n_pe + n_fe + n_ov - e0 !== 0) begin
            errors++; $display("FAIL glitch: got bytes=%0d errs=%0d want 0/0", n_bv - b0, n_pe + n_fe + n_ov - e0);
        end
        // leave a line pending so reset has something to clear
        line_ready = 1'b0;
        send_ok(8'h0D);
        hold_bits(1'b1, CPB);
        hold_bits(1'b0, CPB);
        hold_bits(1'b1, CPB);
        hold_bits(1'b0, CPB / 2);
        rx = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        line_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (line_valid !== 1'b0 || line_data !== 40'h0 || line_len !== 3'd0 || byte_data !== 8'h00) begin
            errors++; $display("FAIL midreset: got lv=%b ld=%h ll=%0d bd=%h want 0", line_valid, line_data, line_len, byte_data);
        end
        b0 = n_bv;
        hold_bits(1'b1, 4 * CPB);
        checks++;
        if (n_bv - b0 !== 0 || n_pe + n_fe + n_ov - e0 !== 0) begin
            errors++; $display("FAIL midreset_quiet: got bytes=%0d want 0", n_bv - b0);
        end
        send_ok(8'h5A); send_ok(8'h0D);
        hold_bits(1'b1, CPB);
        checks++;
        if (n_bv - b0 !== 2 || s_ld !== 40'h5A0D || s_ll !== 3'd2 || s_lt !== 1'b0) begin
            errors++; $display("FAIL post_reset_line: got bytes=%0d data=%h len=%0d want 2/5a0d/2", n_bv - b0, s_ld, s_ll);
        end
    endtask

    initial begin
        test_reset();
        test_hi_line();
        test_parity();
        test_truncate();
        test_frame_err();
        test_overrun();
        test_glitch_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
